// File: rtl/vga_source_switch_ctrl.sv
// vga_source_switch_ctrl: frame-aligned VGA source select with forced-blank resync window (optional AUTO_CYCLE_EN auto-toggle).
module vga_source_switch_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_FRAMES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CYCLE_FRAMES   = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic req_sel_valid,
  input  logic req_sel,
  input  logic vs_0,
  input  logic vs_1,
  output logic sel,
  output logic force_blank,
  output logic busy,
  output logic done,
  output logic timeout
);
  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 21) ? $clog2(TIMEOUT_CYCLES) : 21;
  typedef enum logic [1:0] {IDLE, WAIT_VS, HOLD} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] s0, s1;
  logic d0, d1, cur_fall, tmo, to_exit, go, go_tgt, accept, sw, fin, target;
  logic [TW-1:0] tcnt;
  logic [3:0] hcnt;
  // synchronizers idle high so reset release never fakes a frame start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= '1;
      s1 <= '1;
      d0 <= 1'b1;
      d1 <= 1'b1;
    end else begin
      s0 <= {s0[SYNC_STAGES-2:0], vs_0};
      s1 <= {s1[SYNC_STAGES-2:0], vs_1};
      d0 <= s0[SYNC_STAGES-1];
      d1 <= s1[SYNC_STAGES-1];
    end
  assign cur_fall = sel ? (d1 & ~s1[SYNC_STAGES-1]) : (d0 & ~s0[SYNC_STAGES-1]);
  assign tmo      = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign to_exit  = tmo && !cur_fall && state != IDLE;
`ifdef AUTO_CYCLE_EN
  localparam int FW = $clog2(CYCLE_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic auto_req;
  assign auto_req = state == IDLE && cur_fall && fcnt == FW'(CYCLE_FRAMES - 1);
  assign go       = req | auto_req;
  assign go_tgt   = (req && req_sel_valid) ? req_sel : ~sel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fcnt <= '0;
    else if (state == IDLE) fcnt <= (req || auto_req) ? '0 : cur_fall ? fcnt + 1'b1 : fcnt;
`else
  assign go     = req;
  assign go_tgt = req_sel_valid ? req_sel : ~sel;
`endif
  assign accept = state == IDLE && go && go_tgt != sel;
  assign sw     = state == WAIT_VS && (cur_fall || tmo);
  assign fin    = state == HOLD && ((cur_fall && hcnt <= 4'd1) || to_exit);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HOLD;
    else state <= state_nxt;
  always_comb state_nxt = accept ? WAIT_VS : sw ? HOLD : fin ? IDLE : state;
  always_comb begin
    busy        = state != IDLE;
    force_blank = state == HOLD;
  end
  // sel moves on the same edge the FSM enters HOLD, so blanking starts with the new source
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel     <= 1'b0;
      target  <= 1'b0;
      hcnt    <= 4'(HOLD_FRAMES);
      tcnt    <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= fin;
      timeout <= to_exit;
      target  <= accept ? go_tgt : target;
      sel     <= sw ? target : sel;
      hcnt    <= sw ? 4'(HOLD_FRAMES) : (state == HOLD && cur_fall) ? hcnt - 4'd1 : hcnt;
      tcnt    <= (accept || sw || cur_fall) ? '0 : (state != IDLE) ? tcnt + 1'b1 : tcnt;
    end
endmodule

// File: tb/tb_vga_source_switch_ctrl.sv
// tb_vga_source_switch_ctrl: scoreboard bench for switch/done events of vga_source_switch_ctrl.
module tb_vga_source_switch_ctrl;
  localparam int SYNC = 2, HOLD = 2, TMO = 100, PER = 60;
  logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, req_sel_valid = 1'b0, req_sel = 1'b0;
  logic vs_0 = 1'b1, vs_1 = 1'b1;
  logic sel, force_blank, busy, done, timeout;
  typedef struct {bit is_done; bit sel; bit to;} ev_t;
  ev_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, req_cyc = 0;
  int ph[2] = '{0, 30};
  bit en[2] = '{0, 0};
  bit cur[2] = '{1, 1};
  int last_fall[2] = '{0, 0};
  int fall_count[2] = '{0, 0};
  int snap = 0;
  bit last_to = 0, prev_sel = 0;
  vga_source_switch_ctrl #(.SYNC_STAGES(SYNC), .HOLD_FRAMES(HOLD), .TIMEOUT_CYCLES(TMO), .CYCLE_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel_valid(req_sel_valid), .req_sel(req_sel),
    .vs_0(vs_0), .vs_1(vs_1), .sel(sel), .force_blank(force_blank), .busy(busy),
    .done(done), .timeout(timeout));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // VSYNC generators: active-low pulse of 6 cycles every PER cycles, sources 30 cycles apart
  initial forever begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      bit nv;
      ph[i] = (ph[i] + 1) % PER;
      nv = !(en[i] && ph[i] < 6);
      if (cur[i] && !nv) begin
        last_fall[i] = cyc;
        fall_count[i]++;
      end
      cur[i] = nv;
    end
    vs_0 = cur[0];
    vs_1 = cur[1];
  end
  always @(negedge clk) begin
    ev_t e;
    bit sw_ev;
    sw_ev = 0;
    if (!rst_n) begin
      prev_sel = sel;
      snap = fall_count[0];
      last_to = 0;
    end else begin
      if (sel !== prev_sel) begin
        sw_ev = 1;
        if (exp_q.size() == 0) check("unexpected_switch", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sw_kind", e.is_done, 0);
          check("sw_sel", sel, e.sel);
          check("sw_blank", force_blank, 1);
          check("sw_busy", busy, 1);
          check("sw_timeout", timeout, e.to);
          if (e.to) check("sw_timeout_latency", cyc - req_cyc, TMO);
          else check("sw_vs_latency", cyc - last_fall[prev_sel], SYNC + 1);
          last_to = e.to;
          snap = fall_count[sel];
        end
        prev_sel = sel;
      end
      if (done) begin
        sw_ev = 1;
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("done_kind", e.is_done, 1);
          check("done_sel", sel, e.sel);
          check("done_blank", force_blank, 0);
          check("done_busy", busy, 0);
          check("done_timeout", timeout, e.to);
          check("done_vs_latency", cyc - last_fall[sel], SYNC + 1);
          if (!last_to) check("hold_frames", fall_count[sel] - snap, HOLD);
        end
      end
      if (timeout && !sw_ev) check("stray_timeout", timeout, 0);
    end
  end
  task automatic push(input bit is_done, input bit s, input bit to);
    ev_t e;
    e.is_done = is_done;
    e.sel = s;
    e.to = to;
    exp_q.push_back(e);
  endtask
  task automatic pulse_req(input bit v, input bit s);
    @(posedge clk);
    #2;
    req = 1'b1;
    req_sel_valid = v;
    req_sel = s;
    req_cyc = cyc + 1;
    @(posedge clk);
    #2;
    req = 1'b0;
    req_sel_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    for (int n = 0; n < 600 && busy; n++) @(negedge clk);
    check(tag, busy, 0);
  endtask
  task automatic wait_phase(input int i, input int p);
    for (int n = 0; n < 2 * PER && ph[i] != p; n++) @(posedge clk);
    #2;
  endtask
  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("rst_sel", sel, 0);
    check("rst_blank", force_blank, 1);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    push(1, 0, 0);
    repeat (2) @(posedge clk);
    en[0] = 1;
    en[1] = 1;
    wait_idle("powerup_idle");
    // mid-frame toggle to source 1
    wait_phase(0, 20);
    push(0, 1, 0);
    push(1, 1, 0);
    pulse_req(0, 0);
    check("t2_sel_held", sel, 0);
    wait_idle("toggle_idle");
    // explicit target equal to current source is a no-op
    pulse_req(1, 1);
    repeat (3) @(negedge clk);
    check("noop_busy", busy, 0);
    check("noop_sel", sel, 1);
    // dead current source forces a timeout switch
    en[1] = 0;
    repeat (8) @(posedge clk);
    push(0, 0, 1);
    push(1, 0, 0);
    pulse_req(0, 0);
    wait_idle("timeout_idle");
    en[1] = 1;
    // extra requests while busy are dropped; vs_1 falls during WAIT_VS are ignored
    wait_phase(0, 8);
    push(0, 1, 0);
    push(1, 1, 0);
    pulse_req(0, 0);
    for (int n = 0; n < 600 && busy; n++) begin
      @(posedge clk);
      #2;
      req = busy && (n % 7 == 3);
    end
    req = 1'b0;
    check("extra_idle", busy, 0);
    repeat (5) @(negedge clk);
    check("extra_sel", sel, 1);
    // switch back, then reset asynchronously during the next HOLD
    push(0, 0, 0);
    push(1, 0, 0);
    pulse_req(0, 0);
    wait_idle("back_idle");
    push(0, 1, 0);
    pulse_req(1, 1);
    for (int n = 0; n < 300 && sel !== 1'b1; n++) @(negedge clk);
    check("pre_rst_sel", sel, 1);
    @(negedge clk);
    #1;
    en[0] = 0;
    en[1] = 0;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", sel, 0);
    check("async_rst_blank", force_blank, 1);
    check("async_rst_busy", busy, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    push(1, 0, 0);
    repeat (2) @(posedge clk);
    en[0] = 1;
    en[1] = 1;
    wait_idle("rst_hold_idle");
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_source_switch_ctrl.md
Name: vga_source_switch_ctrl

Overview:
Controller that drives the select line of the two-source VGA output mux. Switch requests come from a user key or a host. The block changes the select only at the start of vertical sync of the source currently on screen, so the switch never lands mid-frame. After each switch it holds a forced-blank window so the monitor can resync. Sits between the key/debounce logic and the VGA output mux on the DE2-115 VGA demo.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each asynchronous VSYNC input (min 2)
HOLD_FRAMES, 2, frames of the new source during which force_blank stays asserted after a switch (1..15)
TIMEOUT_CYCLES, 2000000, clk cycles to wait for a VSYNC edge before switching anyway (dead source)
CYCLE_FRAMES, 300, frames between automatic switches (used only with the optional feature)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
req  in  1  single-cycle pulse requesting a switch to the other source
req_sel_valid  in  1  when high with req, the target is req_sel instead of toggling
req_sel  in  1  explicit target source (0/1)
vs_0  in  1  VSYNC of source 0, active-low, asynchronous to clk
vs_1  in  1  VSYNC of source 1, active-low, asynchronous to clk
sel  out  1  mux select (0 = source 0, 1 = source 1)
force_blank  out  1  high = downstream forces BLANK low (black output)
busy  out  1  high while a switch is pending or holding
done  out  1  one-cycle pulse when the hold window ends
timeout  out  1  one-cycle pulse when a switch was forced by timeout

Behaviour:
- Reset values (async, rst_n low): sel=0, force_blank=1, busy=1, done=0, timeout=0, state=HOLD with hold count=HOLD_FRAMES, target=0. Power-up therefore blanks for HOLD_FRAMES frames of source 0.
- vs_0 and vs_1 each pass through a SYNC_STAGES synchronizer. Frame-start event = falling edge of the synchronized VSYNC (1 -> 0), detected with one extra register. Only the event from the source currently selected by sel (cur_vs_fall) is used.
- Latency from a raw VSYNC falling edge to the internal event is SYNC_STAGES+1 cycles.
- States:
  - IDLE: busy=0, force_blank=0. A req accepted here loads target (req_sel if req_sel_valid, else ~sel), clears the timeout counter and moves to WAIT_VS. If target == sel, the req is ignored and the block stays in IDLE with no done pulse.
  - WAIT_VS: busy=1. Either cur_vs_fall or the timeout counter reaching TIMEOUT_CYCLES-1 ends this state. On exit: sel<=target, force_blank<=1, hold count<=HOLD_FRAMES, next state HOLD. On the timeout exit only, timeout pulses for 1 cycle. The timeout counter is 21 bits minimum and sized by $clog2(TIMEOUT_CYCLES).
  - HOLD: force_blank=1. Each cur_vs_fall (from the new source) decrements the hold count. When the count reaches 0: force_blank<=0, busy<=0, done pulses for 1 cycle, next state IDLE. A dead new source also times out here; on timeout, done and timeout pulse together and the block returns to IDLE.
- sel changes on the same clk edge that force_blank rises, so downstream never sees a glitched frame unblanked.
- req while busy (WAIT_VS or HOLD): ignored and dropped, not queued. req in the same cycle as the HOLD->IDLE transition is also dropped.
- A VSYNC event from the non-selected source is ignored in every state.
- Reset asserted mid-switch returns the block to the reset state immediately. No partial switch state survives.

Optional Feature:
AUTO_CYCLE_EN
- Defined: a frame counter increments on cur_vs_fall while in IDLE. On reaching CYCLE_FRAMES it generates an internal toggle request (identical to req with req_sel_valid=0) and clears. An external req in IDLE also clears the counter. The counter freezes while busy.
- Not defined: no frame counter; switches occur only on req. CYCLE_FRAMES is unused.

Test Plan:
- Reset release with vs_0 toggling at a 1000-cycle period -> force_blank=1 and sel=0 until the 2nd vs_0 falling edge; then done pulses once, force_blank=0, busy=0.
- IDLE with req (req_sel_valid=0) at mid-frame -> sel stays 0 until the next vs_0 fall (+SYNC_STAGES+1 cycles); then sel=1 and force_blank=1; after 2 vs_1 falls, done pulses and force_blank=0.
- req with req_sel_valid=1, req_sel=0 while sel=0 -> no state change; busy stays 0; no done.
- vs_0 held high, TIMEOUT_CYCLES=100, req -> after 100 cycles timeout pulses, sel=1, and HOLD completes on the vs_1 edges.
- Extra req pulses during WAIT_VS and HOLD, plus vs_1 edges during WAIT_VS with sel=0 -> exactly one switch and one done; no early exit from WAIT_VS.
- rst_n pulsed low during HOLD -> sel=0, force_blank=1, busy=1 immediately (asynchronous, no clk edge needed). With AUTO_CYCLE_EN and CYCLE_FRAMES=3 -> sel toggles after every 3 idle frames.
